// File: rtl/fcvt_x_s.sv
// fcvt_x_s: multi-cycle single-precision float to integer converter.
// Signed/unsigned, five static rounding modes, NV/NX flags.
module fcvt_x_s #(
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_input,
  output logic                 ready,
  input  logic [31:0]          a,
  input  logic                 is_signed,
  input  logic [2:0]           rm,
  output logic                 valid_output,
  output logic [OUT_WIDTH-1:0] y,
  output logic [4:0]           fflags
);

  localparam int W = OUT_WIDTH;

  localparam logic [W:0]   SMAX  = {2'b00, {(W-1){1'b1}}};
  localparam logic [W:0]   SMIN  = {2'b01, {(W-1){1'b0}}};
  localparam logic [W-1:0] POS_S = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_S = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] UMAX  = '1;

  typedef enum logic [2:0] {
    IDLE, UNPACK, ALIGN, ROUND, PACK
  } state_t;

  state_t state;

  logic [31:0] a_q;
  logic        sgd_q;
  logic [2:0]  rm_q;
  logic        nan_q;
  logic        inf_q;
  logic [23:0] sig_q;
  logic [8:0]  e_q;
  logic [W:0]  i_q;
  logic        r_q;
  logic        s_q;
  logic        ovf_q;

  logic [W+23:0] full;
  logic [W:0]    i_d;
  logic          r_d;
  logic          s_d;
  logic          ovf_d;

  // e_q is two's complement; bit 8 set means magnitude < 1
  always_comb begin
    full  = {{W{1'b0}}, sig_q} << e_q[6:0];
    i_d   = '0;
    r_d   = 1'b0;
    s_d   = 1'b0;
    ovf_d = 1'b0;
    if (e_q[8]) begin
      r_d = (e_q == 9'h1FF);
      s_d = r_d ? |sig_q[22:0] : |sig_q;
    end else if (e_q[7:0] >= 8'(W)) begin
      ovf_d = 1'b1;
    end else begin
      i_d = full[W+23:23];
      r_d = full[22];
      s_d = |full[21:0];
    end
  end

  logic       sign;
  logic       inc;
  logic [W:0] m;

  assign sign = a_q[31];

  always_comb begin
    inc = 1'b0;
    case (rm_q)
      3'b000:  inc = r_q & (s_q | i_q[0]);
      3'b010:  inc = sign & (r_q | s_q);
      3'b011:  inc = ~sign & (r_q | s_q);
      3'b100:  inc = r_q;
      default: inc = 1'b0;
    endcase
    m = i_q + {{W{1'b0}}, inc};
  end

  logic [W-1:0] sat_pos;
  logic [W-1:0] sat_neg;
  logic [W-1:0] y_d;
  logic         over;
  logic         nv;
  logic         nx;

  always_comb begin
    sat_pos = sgd_q ? POS_S : UMAX;
    sat_neg = sgd_q ? NEG_S : '0;
    y_d     = '0;
    nv      = 1'b0;
    nx      = 1'b0;
    if (sign)
      over = sgd_q ? (m > SMIN) : (m != '0);
    else
      over = sgd_q ? (m > SMAX) : m[W];
    if (nan_q) begin
      y_d = sat_pos;
      nv  = 1'b1;
    end else if (inf_q | ovf_q | over) begin
      y_d = sign ? sat_neg : sat_pos;
      nv  = 1'b1;
    end else begin
      y_d = sign ? -m[W-1:0] : m[W-1:0];
      nx  = r_q | s_q;
    end
  end

  assign ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      valid_output <= 1'b0;
      y            <= '0;
      fflags       <= '0;
      a_q          <= '0;
      sgd_q        <= 1'b0;
      rm_q         <= '0;
      nan_q        <= 1'b0;
      inf_q        <= 1'b0;
      sig_q        <= '0;
      e_q          <= '0;
      i_q          <= '0;
      r_q          <= 1'b0;
      s_q          <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_input) begin
            a_q   <= a;
            sgd_q <= is_signed;
            rm_q  <= rm;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          nan_q <= (&a_q[30:23]) & (|a_q[22:0]);
          inf_q <= (&a_q[30:23]) & ~(|a_q[22:0]);
          sig_q <= {|a_q[30:23], a_q[22:0]};
          e_q   <= {1'b0, a_q[30:23]} - 9'd127;
          state <= ALIGN;
        end
        ALIGN: begin
          i_q   <= i_d;
          r_q   <= r_d;
          s_q   <= s_d;
          ovf_q <= ovf_d;
          state <= ROUND;
        end
        ROUND: begin
          y            <= y_d;
          fflags       <= {nv, 3'b000, nx};
          valid_output <= 1'b1;
          state        <= PACK;
        end
        PACK: begin
          valid_output <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fcvt_x_s.sv
// tb_fcvt_x_s: directed-vector bench for fcvt_x_s.
// Runs a 32-bit and a 64-bit instance off shared stimulus.
module tb_fcvt_x_s;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_input = 1'b0;
  logic [31:0] a = '0;
  logic        is_signed = 1'b0;
  logic [2:0]  rm = '0;

  logic        rdy32, vo32, rdy64, vo64;
  logic [31:0] y32;
  logic [63:0] y64;
  logic [4:0]  f32, f64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fcvt_x_s #(.OUT_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .valid_input(valid_input), .ready(rdy32),
    .a(a), .is_signed(is_signed), .rm(rm),
    .valid_output(vo32), .y(y32), .fflags(f32)
  );

  fcvt_x_s #(.OUT_WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .valid_input(valid_input), .ready(rdy64),
    .a(a), .is_signed(is_signed), .rm(rm),
    .valid_output(vo64), .y(y64), .fflags(f64)
  );

  task automatic do_conv(input logic [31:0] op, input logic sg,
                         input logic [2:0] m);
    int n;
    @(negedge clk);
    a = op; is_signed = sg; rm = m; valid_input = 1'b1;
    @(negedge clk);
    valid_input = 1'b0;
    n = 0;
    while (!vo32 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!vo32) begin
      errors++;
      $display("FAIL conv_timeout op=%h no valid_output", op);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b want=1", rdy32); end
    checks++; if (vo32 !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", vo32); end
    checks++; if (y32 !== 32'h0) begin errors++; $display("FAIL rst_y got=%h want=0", y32); end
    checks++; if (f32 !== 5'h0) begin errors++; $display("FAIL rst_flags got=%h want=0", f32); end
    checks++; if (y64 !== 64'h0) begin errors++; $display("FAIL rst_y64 got=%h want=0", y64); end
    rst = 1'b0;
  endtask

  task automatic test_rounding;
    do_conv(32'h40200000, 1'b1, 3'b000);
    checks++; if (y32 !== 32'd2 || f32 !== 5'h01) begin errors++; $display("FAIL rne_2p5 got=%h/%h want=2/01", y32, f32); end
    do_conv(32'h40200000, 1'b1, 3'b100);
    checks++; if (y32 !== 32'd3 || f32 !== 5'h01) begin errors++; $display("FAIL rmm_2p5 got=%h/%h want=3/01", y32, f32); end
    do_conv(32'h40200000, 1'b1, 3'b011);
    checks++; if (y32 !== 32'd3) begin errors++; $display("FAIL rup_2p5 got=%h want=3", y32); end
    do_conv(32'h40200000, 1'b1, 3'b001);
    checks++; if (y32 !== 32'd2) begin errors++; $display("FAIL rtz_2p5 got=%h want=2", y32); end
    do_conv(32'h40200000, 1'b1, 3'b111);
    checks++; if (y32 !== 32'd2) begin errors++; $display("FAIL rm7_2p5 got=%h want=2", y32); end
    do_conv(32'h40600000, 1'b1, 3'b000);
    checks++; if (y32 !== 32'd4 || f32 !== 5'h01) begin errors++; $display("FAIL rne_3p5 got=%h/%h want=4/01", y32, f32); end
    do_conv(32'h3F000000, 1'b1, 3'b000);
    checks++; if (y32 !== 32'd0 || f32 !== 5'h01) begin errors++; $display("FAIL rne_0p5 got=%h/%h want=0/01", y32, f32); end
    do_conv(32'hBFC00000, 1'b1, 3'b010);
    checks++; if (y32 !== 32'hFFFFFFFE || f32 !== 5'h01) begin errors++; $display("FAIL rdn_m1p5 got=%h/%h want=fffffffe/01", y32, f32); end
  endtask

  task automatic test_range;
    do_conv(32'h4F000000, 1'b1, 3'b001);
    checks++; if (y32 !== 32'h7FFFFFFF || f32 !== 5'h10) begin errors++; $display("FAIL s_2p31 got=%h/%h want=7fffffff/10", y32, f32); end
    do_conv(32'h4F000000, 1'b0, 3'b001);
    checks++; if (y32 !== 32'h80000000 || f32 !== 5'h00) begin errors++; $display("FAIL u_2p31 got=%h/%h want=80000000/00", y32, f32); end
    do_conv(32'hCF000000, 1'b1, 3'b001);
    checks++; if (y32 !== 32'h80000000 || f32 !== 5'h00) begin errors++; $display("FAIL s_m2p31 got=%h/%h want=80000000/00", y32, f32); end
  endtask

  task automatic test_specials;
    do_conv(32'h7FC00000, 1'b0, 3'b000);
    checks++; if (y32 !== 32'hFFFFFFFF || f32 !== 5'h10) begin errors++; $display("FAIL nan_u got=%h/%h want=ffffffff/10", y32, f32); end
    do_conv(32'hFF800000, 1'b1, 3'b000);
    checks++; if (y32 !== 32'h80000000 || f32 !== 5'h10) begin errors++; $display("FAIL ninf_s got=%h/%h want=80000000/10", y32, f32); end
    do_conv(32'h80000000, 1'b1, 3'b011);
    checks++; if (y32 !== 32'h0 || f32 !== 5'h00) begin errors++; $display("FAIL neg_zero got=%h/%h want=0/00", y32, f32); end
  endtask

  task automatic test_neg_unsigned;
    do_conv(32'hBE99999A, 1'b0, 3'b001);
    checks++; if (y32 !== 32'h0 || f32 !== 5'h01) begin errors++; $display("FAIL u_m0p3 got=%h/%h want=0/01", y32, f32); end
    do_conv(32'hBF800000, 1'b0, 3'b001);
    checks++; if (y32 !== 32'h0 || f32 !== 5'h10) begin errors++; $display("FAIL u_m1 got=%h/%h want=0/10", y32, f32); end
  endtask

  task automatic test_wide;
    do_conv(32'h53800000, 1'b0, 3'b001);
    checks++; if (y64 !== 64'h0000010000000000 || f64 !== 5'h00) begin errors++; $display("FAIL w64_u_2p40 got=%h/%h want=0000010000000000/00", y64, f64); end
    checks++; if (y32 !== 32'hFFFFFFFF || f32 !== 5'h10) begin errors++; $display("FAIL w32_u_2p40 got=%h/%h want=ffffffff/10", y32, f32); end
    do_conv(32'h5F000000, 1'b1, 3'b001);
    checks++; if (y64 !== 64'h7FFFFFFFFFFFFFFF || f64 !== 5'h10) begin errors++; $display("FAIL w64_s_2p63 got=%h/%h want=7fffffffffffffff/10", y64, f64); end
    do_conv(32'hBFC00000, 1'b1, 3'b010);
    checks++; if (y64 !== 64'hFFFFFFFFFFFFFFFE || f64 !== 5'h01) begin errors++; $display("FAIL w64_rdn_m1p5 got=%h/%h want=fffffffffffffffe/01", y64, f64); end
  endtask

  task automatic test_handshake;
    @(negedge clk);
    a = 32'h40200000; is_signed = 1'b1; rm = 3'b001; valid_input = 1'b1;
    @(negedge clk);
    valid_input = 1'b0;
    checks++; if (rdy32 !== 1'b0) begin errors++; $display("FAIL hs_ready_c1 got=%b want=0", rdy32); end
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (vo32 !== (c == 4)) begin
        errors++;
        $display("FAIL hs_valid_c%0d got=%b want=%b", c, vo32, (c == 4));
      end
      if (c < 5) @(negedge clk);
    end
    checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL hs_ready_c5 got=%b want=1", rdy32); end
  endtask

  task automatic test_busy_ignore;
    int pulses;
    pulses = 0;
    @(negedge clk);
    a = 32'h40200000; is_signed = 1'b1; rm = 3'b001; valid_input = 1'b1;
    @(negedge clk);
    a = 32'h4F000000; is_signed = 1'b0; rm = 3'b011;
    for (int c = 1; c <= 3; c++) begin
      if (vo32) pulses++;
      @(negedge clk);
    end
    if (vo32) pulses++;
    valid_input = 1'b0;
    checks++; if (y32 !== 32'd2 || f32 !== 5'h01) begin errors++; $display("FAIL busy_result got=%h/%h want=2/01", y32, f32); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (vo32) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL busy_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    pulses = 0;
    @(negedge clk);
    a = 32'h40600000; is_signed = 1'b1; rm = 3'b000; valid_input = 1'b1;
    @(negedge clk);
    valid_input = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (vo32 !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b want=0", vo32); end
    checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b want=1", rdy32); end
    checks++; if (y32 !== 32'h0) begin errors++; $display("FAIL rmid_y got=%h want=0", y32); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (vo32) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rmid_pulses got=%0d want=0", pulses); end
    do_conv(32'h40600000, 1'b1, 3'b000);
    checks++; if (y32 !== 32'd4) begin errors++; $display("FAIL rmid_after got=%h want=4", y32); end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_range();
    test_specials();
    test_neg_unsigned();
    test_wide();
    test_handshake();
    test_busy_ignore();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
